// File: rtl/ex_div_unit.sv
// ----------------------------------------------------------------------------
// ex_div_unit
//
// Iterative radix-2 restoring divider for the EX stage. Executes div.w,
// div.wu, mod.w and mod.wu. Operands are reduced to magnitudes on accept.
// One quotient bit is produced per cycle over DATA_W cycles. The final
// quotient or remainder is then sign-corrected and registered for writeback.
//
// Optional feature macro: DIV_FAST_PATH_EN
//   When defined, a divide by zero or |dividend| < |divisor| skips the
//   iteration and goes straight to DONE one cycle after accept. Results are
//   identical with or without the macro; only latency changes.
//
// Ports
//   clk         in   1       clock, rising edge
//   resetn      in   1       asynchronous active-low reset
//   flush       in   1       pipeline flush, cancels any in-flight op
//   in_valid    in   1       op presented
//   in_ready    out  1       unit can accept an op (state == IDLE)
//   in_op       in   5       alu_op: 20=div.w 21=div.wu 22=mod.w 23=mod.wu
//   in_src1     in   DATA_W  dividend (rj)
//   in_src2     in   DATA_W  divisor (rk)
//   in_rd       in   5       destination register
//   out_valid   out  1       result available (state == DONE)
//   out_ready   in   1       writeback accepts the result
//   out_result  out  DATA_W  quotient or remainder
//   out_rd      out  5       destination register of the result
//   busy        out  1       state != IDLE
// ----------------------------------------------------------------------------
module ex_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    localparam logic [4:0] OP_DIV_W  = 5'd20;
    localparam logic [4:0] OP_DIV_WU = 5'd21;
    localparam logic [4:0] OP_MOD_W  = 5'd22;
    localparam logic [4:0] OP_MOD_WU = 5'd23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic              negQuo_q, negQuo_d;
    logic              negRem_q, negRem_d;
    logic              isRem_q, isRem_d;
    logic              divZero_q, divZero_d;
    logic [DATA_W-1:0] outResult_q, outResult_d;
    logic [4:0]        outRd_q, outRd_d;

    // Decode of the incoming op and operand magnitudes
    logic              opValid;
    logic              opSigned;
    logic              opIsRem;
    logic              sign1;
    logic              sign2;
    logic [DATA_W-1:0] absA;
    logic [DATA_W-1:0] absB;
    logic              accept;

    // One restoring step and the sign-corrected final result
    logic [DATA_W:0]   remWide;
    logic [DATA_W:0]   remDiff;
    logic              stepBit;
    logic [DATA_W-1:0] remNext;
    logic [DATA_W-1:0] quoNext;
    logic [DATA_W-1:0] quoFinal;
    logic [DATA_W-1:0] remFinal;
    logic [DATA_W-1:0] resultCalc;

    // Operand conditioning. Only the signed ops take absolute values; the
    // signs are remembered so the magnitude result can be corrected later.
    // The most negative value maps onto itself, which is its correct unsigned
    // magnitude, so signed overflow needs no special handling.
    always_comb begin
        opValid  = (in_op == OP_DIV_W) || (in_op == OP_DIV_WU) ||
                   (in_op == OP_MOD_W) || (in_op == OP_MOD_WU);
        opSigned = (in_op == OP_DIV_W) || (in_op == OP_MOD_W);
        opIsRem  = (in_op == OP_MOD_W) || (in_op == OP_MOD_WU);
        sign1    = opSigned & in_src1[DATA_W-1];
        sign2    = opSigned & in_src2[DATA_W-1];
        absA     = sign1 ? ({DATA_W{1'b0}} - in_src1) : in_src1;
        absB     = sign2 ? ({DATA_W{1'b0}} - in_src2) : in_src2;
        accept   = in_valid & (state_q == IDLE) & opValid & ~flush;
    end

    // Restoring step: the partial remainder is widened by one bit so the
    // shifted value never overflows before the compare. The dividend lives in
    // the quotient register and shifts out MSB-first while quotient bits shift
    // in from the bottom. A zero divisor yields all-ones quotient bits and a
    // remainder equal to the dividend magnitude, which the sign fix-up below
    // turns back into the original src1.
    always_comb begin
        remWide    = {rem_q, quo_q[DATA_W-1]};
        remDiff    = remWide - {1'b0, divisor_q};
        stepBit    = (remWide >= {1'b0, divisor_q});
        remNext    = stepBit ? remDiff[DATA_W-1:0] : remWide[DATA_W-1:0];
        quoNext    = {quo_q[DATA_W-2:0], stepBit};
        quoFinal   = divZero_q ? {DATA_W{1'b1}}
                   : (negQuo_q ? ({DATA_W{1'b0}} - quoNext) : quoNext);
        remFinal   = negRem_q ? ({DATA_W{1'b0}} - remNext) : remNext;
        resultCalc = isRem_q ? remFinal : quoFinal;
    end

    // Next-state and datapath update. Flush wins over everything, including
    // the final CALC step, so a cancelled op never reaches the result register.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        negQuo_d    = negQuo_q;
        negRem_d    = negRem_q;
        isRem_d     = isRem_q;
        divZero_d   = divZero_q;
        outResult_d = outResult_q;
        outRd_d     = outRd_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d   = CALC;
                        count_d   = '0;
                        rem_d     = '0;
                        quo_d     = absA;
                        divisor_d = absB;
                        negQuo_d  = sign1 ^ sign2;
                        negRem_d  = sign1;
                        isRem_d   = opIsRem;
                        divZero_d = (in_src2 == '0);
                        outRd_d   = in_rd;
`ifdef DIV_FAST_PATH_EN
                        // Quotient is trivially 0 (or all ones for /0) and the
                        // remainder is the untouched dividend.
                        if ((in_src2 == '0) || (absA < absB)) begin
                            state_d     = DONE;
                            outResult_d = opIsRem ? in_src1
                                        : ((in_src2 == '0) ? {DATA_W{1'b1}}
                                                           : {DATA_W{1'b0}});
                        end
`endif
                    end
                end
                CALC: begin
                    rem_d = remNext;
                    quo_d = quoNext;
                    if (count_q == LAST_STEP) begin
                        state_d     = DONE;
                        outResult_d = resultCalc;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
            isRem_q     <= 1'b0;
            divZero_q   <= 1'b0;
            outResult_q <= '0;
            outRd_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            negQuo_q    <= negQuo_d;
            negRem_q    <= negRem_d;
            isRem_q     <= isRem_d;
            divZero_q   <= divZero_d;
            outResult_q <= outResult_d;
            outRd_q     <= outRd_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = outResult_q;
    assign out_rd     = outRd_q;

endmodule
